// File: rtl/raw_pattern_gen.sv
// Raw Bayer-domain test pattern source: programmable frame geometry, 1/2/4 pixels per beat,
// run-time pattern select, start/pause/done control and frame/line markers.
module raw_pattern_gen #(
    parameter int              DATA_WIDTH  = 10,
    parameter int              PIX_PER_CLK = 1,
    parameter int              HSIZE       = 6,
    parameter int              VSIZE       = 6,
    parameter int              H_BLANK     = 3,
    parameter int              V_BLANK     = 1,
    parameter int              FRAME_NUM   = 1,
    parameter int              CHK_SHIFT   = 1,
    parameter logic [DATA_WIDTH-1:0] R_VAL  = 'h200,
    parameter logic [DATA_WIDTH-1:0] GR_VAL = 'h100,
    parameter logic [DATA_WIDTH-1:0] GB_VAL = 'h0C0,
    parameter logic [DATA_WIDTH-1:0] B_VAL  = 'h080,
    parameter logic [15:0]     LFSR_SEED   = 16'hACE1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic                              data_req_in,
    input  logic [2:0]                        mode_in,
    output logic                              data_valid_out,
    output logic [DATA_WIDTH*PIX_PER_CLK-1:0] data_out,
    output logic                              sof_out,
    output logic                              eol_out,
    output logic                              eof_out,
    output logic [11:0]                       frame_cnt_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int BEATS       = HSIZE / PIX_PER_CLK;
    localparam int LINE_BEATS  = BEATS + H_BLANK;
    localparam int FRAME_LINES = VSIZE + V_BLANK;
    localparam int BX_W        = $clog2(LINE_BEATS + 1);
    localparam int LY_W        = $clog2(FRAME_LINES + 1);
    localparam int PW          = DATA_WIDTH * PIX_PER_CLK;

    localparam logic [63:0] GRAD_FULL = 64'd1 << DATA_WIDTH;
    localparam logic [31:0] GRAD_STEP = 32'(GRAD_FULL / 64'(HSIZE));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_reg;
    logic [BX_W-1:0] beat_x_reg;
    logic [LY_W-1:0] line_y_reg;
    logic [11:0]     frame_cnt_reg;
    logic [2:0]      mode_reg;
    logic [15:0]     lfsr_reg;
    logic            valid_reg;
    logic [PW-1:0]   data_reg;
    logic            sof_reg;
    logic            eol_reg;
    logic            eof_reg;

    // Fibonacci LFSR, taps 16,14,13,11, stepped a constant number of times.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] s, input int steps);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < steps; i++)
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        return t;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pixel_value(input logic [2:0] mode,
                                                           input logic [31:0] x,
                                                           input logic [31:0] y,
                                                           input logic [15:0] lfsr);
        logic [DATA_WIDTH+15:0] lfsr_ext;
        logic [31:0]            chk;
        lfsr_ext    = {{DATA_WIDTH{1'b0}}, lfsr};
        chk         = (x >> CHK_SHIFT) ^ (y >> CHK_SHIFT);
        pixel_value = '0;
        case (mode)
            3'd0: pixel_value = DATA_WIDTH'(y * 32'(HSIZE) + x);
            3'd1: pixel_value = DATA_WIDTH'(x * GRAD_STEP);
            3'd2: begin
                case ({y[0], x[0]})
                    2'b00:   pixel_value = R_VAL;
                    2'b01:   pixel_value = GR_VAL;
                    2'b10:   pixel_value = GB_VAL;
                    default: pixel_value = B_VAL;
                endcase
            end
            3'd3: pixel_value = chk[0] ? '1 : '0;
            3'd4: pixel_value = lfsr_ext[DATA_WIDTH-1:0];
            default: pixel_value = '0;
        endcase
    endfunction

    logic          active;
    logic          line_last;
    logic          frame_last_line;
    logic [11:0]   frame_cnt_inc;
    logic          last_frame;
    logic [PW-1:0] lane_pix;
    logic [31:0]   pix_y;
    logic [15:0]   lfsr_next;

    assign active          = (line_y_reg < LY_W'(VSIZE)) && (beat_x_reg < BX_W'(BEATS));
    assign line_last       = (beat_x_reg == BX_W'(LINE_BEATS - 1));
    assign frame_last_line = (line_y_reg == LY_W'(FRAME_LINES - 1));
    assign frame_cnt_inc   = frame_cnt_reg + 12'd1;
    assign last_frame      = (FRAME_NUM != 0) && (frame_cnt_inc == 12'(FRAME_NUM));
    assign pix_y           = 32'(line_y_reg);
    assign lfsr_next       = lfsr_advance(lfsr_reg, PIX_PER_CLK);

    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_CLK; gi++) begin : g_lane
            logic [31:0] pix_x;
            logic [15:0] lane_lfsr;
            assign pix_x     = 32'(beat_x_reg) * 32'(PIX_PER_CLK) + 32'(gi);
            assign lane_lfsr = lfsr_advance(lfsr_reg, gi);
            assign lane_pix[gi*DATA_WIDTH +: DATA_WIDTH] = pixel_value(mode_reg, pix_x, pix_y, lane_lfsr);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            beat_x_reg    <= '0;
            line_y_reg    <= '0;
            frame_cnt_reg <= '0;
            mode_reg      <= '0;
            lfsr_reg      <= LFSR_SEED;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            eof_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!data_req_in) begin
                        valid_reg <= 1'b0;
                        sof_reg   <= 1'b0;
                        eol_reg   <= 1'b0;
                        eof_reg   <= 1'b0;
                    end else begin
                        valid_reg <= active;
                        data_reg  <= active ? lane_pix : '0;
                        sof_reg   <= active && (beat_x_reg == '0) && (line_y_reg == '0);
                        eol_reg   <= active && (beat_x_reg == BX_W'(BEATS - 1));
                        eof_reg   <= active && (beat_x_reg == BX_W'(BEATS - 1))
                                     && (line_y_reg == LY_W'(VSIZE - 1));
                        if (active)
                            lfsr_reg <= lfsr_next;
                        if (!line_last) begin
                            beat_x_reg <= beat_x_reg + BX_W'(1);
                        end else if (!frame_last_line) begin
                            beat_x_reg <= '0;
                            line_y_reg <= line_y_reg + LY_W'(1);
                        end else begin
                            frame_cnt_reg <= frame_cnt_inc;
                            if (last_frame) begin
                                state_reg <= ST_DONE;
                            end else begin
                                // Next frame: restart geometry, pattern and noise sequence.
                                beat_x_reg <= '0;
                                line_y_reg <= '0;
                                mode_reg   <= mode_in;
                                lfsr_reg   <= LFSR_SEED;
                            end
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    sof_reg   <= 1'b0;
                    eol_reg   <= 1'b0;
                    eof_reg   <= 1'b0;
                    if (start_in) begin
                        state_reg     <= ST_RUN;
                        beat_x_reg    <= '0;
                        line_y_reg    <= '0;
                        frame_cnt_reg <= '0;
                        mode_reg      <= mode_in;
                        lfsr_reg      <= LFSR_SEED;
                    end
                end
            endcase
        end
    end

    assign data_valid_out = valid_reg;
    assign data_out       = data_reg;
    assign sof_out        = sof_reg;
    assign eol_out        = eol_reg;
    assign eof_out        = eof_reg;
    assign frame_cnt_out  = frame_cnt_reg;
    assign busy_out       = (state_reg == ST_RUN);
    assign done_out       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Directed bench for raw_pattern_gen: three instances cover default geometry,
// two pixels per beat, and free-running LFSR frames.
module tb_raw_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req;
    logic        start0, start1, start2;
    logic [2:0]  mode0, mode1, mode2;

    logic        v0, sof0, eol0, eof0, busy0, done0;
    logic [9:0]  d0;
    logic [11:0] fc0;
    logic        v1, sof1, eol1, eof1, busy1, done1;
    logic [19:0] d1;
    logic [11:0] fc1;
    logic        v2, sof2, eol2, eof2, busy2, done2;
    logic [9:0]  d2;
    logic [11:0] fc2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    raw_pattern_gen dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .data_req_in(data_req),
        .mode_in(mode0), .data_valid_out(v0), .data_out(d0), .sof_out(sof0),
        .eol_out(eol0), .eof_out(eof0), .frame_cnt_out(fc0), .busy_out(busy0),
        .done_out(done0)
    );

    raw_pattern_gen #(.PIX_PER_CLK(2), .HSIZE(8)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .data_req_in(data_req),
        .mode_in(mode1), .data_valid_out(v1), .data_out(d1), .sof_out(sof1),
        .eol_out(eol1), .eof_out(eof1), .frame_cnt_out(fc1), .busy_out(busy1),
        .done_out(done1)
    );

    raw_pattern_gen #(.FRAME_NUM(0)) dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .data_req_in(data_req),
        .mode_in(mode2), .data_valid_out(v2), .data_out(d2), .sof_out(sof2),
        .eol_out(eol2), .eof_out(eof2), .frame_cnt_out(fc2), .busy_out(busy2),
        .done_out(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] ok %s = %0h", tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; data_req = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0 = 3'd0; mode1 = 3'd0; mode2 = 3'd0;
        #2 rst_n = 1'b0;
        tick(); tick();
        check("reset_dut0", {v0, sof0, eol0, eof0, busy0, done0, fc0, d0}, 64'd0);
        check("reset_dut1", {v1, sof1, eol1, eof1, busy1, done1, fc1, d1}, 64'd0);
        check("reset_dut2", {v2, sof2, eol2, eof2, busy2, done2, fc2, d2}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Ramp frame with default geometry.
        mode0 = 3'd0; start0 = 1'b1; tick(); start0 = 1'b0;
        check("ramp_c1_valid", v0, 0);
        check("ramp_c1_busy", busy0, 1);
        for (int y = 0; y < 6; y++) begin
            for (int bx = 0; bx < 9; bx++) begin
                tick();
                if (bx < 6) begin
                    check($sformatf("ramp_v_y%0d_b%0d", y, bx), v0, 1);
                    check($sformatf("ramp_d_y%0d_b%0d", y, bx), d0, y * 6 + bx);
                    check($sformatf("ramp_mk_y%0d_b%0d", y, bx), {sof0, eol0, eof0},
                          {y == 0 && bx == 0, bx == 5, y == 5 && bx == 5});
                end else begin
                    check($sformatf("ramp_blank_y%0d_b%0d", y, bx), {v0, sof0, eol0, eof0}, 0);
                end
            end
        end
        for (int j = 0; j < 9; j++) begin
            tick();
            check($sformatf("vblank_v_%0d", j), v0, 0);
            check($sformatf("vblank_done_%0d", j), done0, j == 8);
        end
        check("ramp_fcnt", fc0, 1);
        check("ramp_busy_end", busy0, 0);
        tick();
        check("done_hold", {v0, done0}, 2'b01);

        // Bayer frame restarted from DONE, then aborted by reset inside line 2.
        mode0 = 3'd2; start0 = 1'b1; tick(); start0 = 1'b0;
        check("bayer_fcnt_clear", fc0, 0);
        for (int y = 0; y < 2; y++) begin
            for (int bx = 0; bx < 9; bx++) begin
                tick();
                if (bx < 6)
                    check($sformatf("bayer_y%0d_x%0d", y, bx), {v0, d0},
                          {1'b1, (y == 0) ? ((bx % 2 == 0) ? 10'h200 : 10'h100)
                                          : ((bx % 2 == 0) ? 10'h0C0 : 10'h080)});
                else
                    check($sformatf("bayer_blank_y%0d_b%0d", y, bx), v0, 0);
            end
        end
        tick(); tick(); tick();
        check("bayer_line2_x2", {v0, d0}, {1'b1, 10'h200});
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {v0, sof0, eol0, eof0, busy0, done0, fc0, d0}, 64'd0);
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_after_reset", {v0, busy0, done0}, 0);

        // Restart in ramp mode and pause after pixel 3.
        mode0 = 3'd0; start0 = 1'b1; tick(); start0 = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tick();
            check($sformatf("restart_px%0d", p), {v0, sof0, d0}, {1'b1, p == 0, 10'(p)});
        end
        data_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("pause_v_%0d", k), v0, 0);
        end
        data_req = 1'b1;
        tick();
        check("resume_px4", {v0, d0}, {1'b1, 10'd4});
        tick();
        check("resume_px5", {v0, eol0, d0}, {2'b11, 10'd5});
        tick(); tick(); tick();
        check("resume_hblank", v0, 0);
        tick();
        check("resume_px6", {v0, d0}, {1'b1, 10'd6});

        // Two pixels per beat, HSIZE 8.
        mode1 = 3'd0; start1 = 1'b1; tick(); start1 = 1'b0;
        for (int y = 0; y < 2; y++) begin
            for (int bx = 0; bx < 7; bx++) begin
                tick();
                if (bx < 4) begin
                    check($sformatf("ppc2_d_y%0d_b%0d", y, bx), {v1, d1},
                          {1'b1, 10'(y * 8 + 2 * bx + 1), 10'(y * 8 + 2 * bx)});
                    check($sformatf("ppc2_mk_y%0d_b%0d", y, bx), {sof1, eol1},
                          {y == 0 && bx == 0, bx == 3});
                end else begin
                    check($sformatf("ppc2_blank_y%0d_b%0d", y, bx), v1, 0);
                end
            end
        end

        // Free-running LFSR frames with a mode change during frame 2.
        mode2 = 3'd4; start2 = 1'b1; cyc = 0; tick(); start2 = 1'b0;
        tick();
        check("lfsr_f1_px0", {v2, sof2, d2}, {2'b11, 10'h0E1});
        tick();
        check("lfsr_f1_px1", {v2, d2}, {1'b1, 10'h1C3});
        while (cyc < 63) tick();
        check("lfsr_fcnt_before1", fc2, 0);
        tick();
        check("lfsr_fcnt1", {v2, fc2}, {1'b0, 12'd1});
        tick();
        check("lfsr_f2_px0", {v2, sof2, d2}, {2'b11, 10'h0E1});
        tick();
        check("lfsr_f2_px1", {v2, d2}, {1'b1, 10'h1C3});
        while (cyc < 80) tick();
        mode2 = 3'd0;
        while (cyc < 127) tick();
        check("lfsr_fcnt2", fc2, 2);
        tick();
        check("f3_ramp_px0", {v2, sof2, d2}, {2'b11, 10'd0});
        tick();
        check("f3_ramp_px1", {v2, d2}, {1'b1, 10'd1});
        while (cyc < 190) tick();
        check("lfsr_fcnt3", fc2, 3);
        check("forever_not_done", {busy2, done2}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
